// File: rtl/battle_state_ctrl.sv
// battle_state_ctrl: fight phase FSM with player HP, hit acceptance and optional post-hit invulnerability (BATTLE_INVULN_EN)
module battle_state_ctrl #(
  parameter int HP_INIT = 20,
  parameter int HIT_DAMAGE = 4,
  parameter int INVULN_CYCLES = 50_000_000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       enable,
  input  logic       start,
  input  logic [3:0] hit_vec,
  input  logic       boss_defeated,
  output logic [1:0] phase,
  output logic [4:0] player_hp,
  output logic       hit_pulse,
  output logic       invuln,
  output logic       gen_enable
);
  typedef enum logic [1:0] {IDLE = 2'b00, FIGHT = 2'b01, LOSE = 2'b10, WIN = 2'b11} state_t;
  state_t state;
  logic start_q, hit_q, start_rise, hit_rise, run, can_hit, accept;
  logic [5:0] hp_wide, hp_next;
  assign start_rise = start & ~start_q;
  assign hit_rise = (|hit_vec) & ~hit_q;
  assign run = (state == FIGHT) & enable;
  assign accept = run & ~boss_defeated & hit_rise & can_hit;
  assign hp_wide = {1'b0, player_hp};
  assign hp_next = (hp_wide > 6'(HIT_DAMAGE)) ? hp_wide - 6'(HIT_DAMAGE) : 6'd0;
  assign phase = state;
  assign gen_enable = run;
`ifdef BATTLE_INVULN_EN
  logic [25:0] cnt;
  assign can_hit = ~invuln & (cnt == '0);
  // invulnerability window: loaded by a surviving hit, counts only while the fight runs
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      cnt <= '0;
      invuln <= 1'b0;
    end else if (state == IDLE && start_rise && enable) begin
      cnt <= '0;
      invuln <= 1'b0;
    end else if (run) begin
      cnt <= (accept && hp_next != '0) ? 26'(INVULN_CYCLES) : (cnt != '0) ? cnt - 1'b1 : cnt;
      invuln <= cnt != '0;
    end
`else
  assign can_hit = 1'b1;
  assign invuln = 1'b0;
`endif
  // phase, HP and hit pulse; edge detectors track inputs in every state
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      player_hp <= '0;
      hit_pulse <= 1'b0;
      start_q <= 1'b0;
      hit_q <= 1'b0;
    end else begin
      start_q <= start;
      hit_q <= |hit_vec;
      hit_pulse <= accept;
      case (state)
        IDLE: if (start_rise && enable) begin
          state <= FIGHT;
          player_hp <= 5'(HP_INIT);
        end
        FIGHT: if (run && boss_defeated) state <= WIN;
          else if (accept) begin
            player_hp <= hp_next[4:0];
            if (hp_next == '0) state <= LOSE;
          end
        default: if (start_rise) state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_battle_state_ctrl.sv
// tb_battle_state_ctrl: directed scenarios plus randomized run against a behavioural fight model
module tb_battle_state_ctrl;
  localparam int HP = 20, DMG = 4, INV = 8;
`ifdef BATTLE_INVULN_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif
  logic clk = 1'b0, resetn = 1'b0, enable = 1'b0, start = 1'b0, boss = 1'b0;
  logic [3:0] hit_vec = '0;
  logic [1:0] phase;
  logic [4:0] player_hp;
  logic hit_pulse, invuln, gen_enable;
  int checks = 0, passed = 0;
  int m_phase, m_hp, m_left;
  bit m_pulse, m_inv, m_sq, m_hq;

  battle_state_ctrl #(.HP_INIT(HP), .HIT_DAMAGE(DMG), .INVULN_CYCLES(INV)) dut (
    .CLOCK_50(clk), .resetn(resetn), .enable(enable), .start(start), .hit_vec(hit_vec),
    .boss_defeated(boss), .phase(phase), .player_hp(player_hp), .hit_pulse(hit_pulse),
    .invuln(invuln), .gen_enable(gen_enable));

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_phase = 0; m_hp = 0; m_left = 0; m_pulse = 0; m_inv = 0; m_sq = 0; m_hq = 0;
  endfunction

  function automatic void model_step();
    bit sr, hr, acc;
    sr = start && !m_sq;
    hr = (hit_vec != 0) && !m_hq;
    acc = 0;
    m_sq = start;
    m_hq = hit_vec != 0;
    if (m_phase == 0) begin
      if (sr && enable) begin m_phase = 1; m_hp = HP; m_left = 0; m_inv = 0; end
    end else if (m_phase == 1) begin
      if (enable) begin
        if (boss) m_phase = 3;
        else if (hr && !m_inv && m_left == 0) begin
          acc = 1;
          m_hp = (m_hp > DMG) ? m_hp - DMG : 0;
          if (m_hp == 0) m_phase = 2;
          else if (INV_EN) m_left = INV + 1;
        end
        m_inv = m_left > 1 || (m_left == 1);
        if (acc) m_inv = 0;
        if (!acc && m_left > 0) m_left--;
        if (!acc && m_left == 0 && !m_inv) m_inv = 0;
      end
    end else if (sr) m_phase = 0;
    m_pulse = acc;
  endfunction

  task automatic tick();
    if (resetn) model_step(); else model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 0;
    tick(); tick();
    checks++; if ({phase, player_hp, hit_pulse, invuln, gen_enable} !== 10'b0) $display("FAIL reset_state got %b want 0", {phase, player_hp, hit_pulse, invuln, gen_enable}); else passed++;
    resetn = 1;
    enable = 1;
    tick();
    checks++; if (phase !== 2'b00) $display("FAIL idle_hold got %0d want 0", phase); else passed++;
  endtask

  task automatic test_start();
    start = 1;
    tick();
    checks++; if (phase !== 2'b01 || player_hp !== 5'(HP) || gen_enable !== 1'b1) $display("FAIL start got phase=%0d hp=%0d gen=%0d want 1/%0d/1", phase, player_hp, gen_enable, HP); else passed++;
    start = 0;
    tick();
  endtask

  task automatic test_held_hit();
    int pulses = 0, inv_cycles = 0;
    hit_vec = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      tick();
      pulses += int'(hit_pulse);
      inv_cycles += int'(invuln);
      if (i == 0) begin
        checks++; if (hit_pulse !== 1'b1 || player_hp !== 5'd16) $display("FAIL first_hit got pulse=%0d hp=%0d want 1/16", hit_pulse, player_hp); else passed++;
      end
    end
    checks++; if (pulses != 1 || player_hp !== 5'd16) $display("FAIL held_hit got pulses=%0d hp=%0d want 1/16", pulses, player_hp); else passed++;
    checks++; if (inv_cycles != (INV_EN ? INV : 0)) $display("FAIL invuln_len got %0d want %0d", inv_cycles, INV_EN ? INV : 0); else passed++;
    hit_vec = 0;
    tick(); tick();
  endtask

  task automatic test_spaced();
    hit_vec = 4'b0001; tick(); hit_vec = 0; tick(); tick();
    checks++; if (player_hp !== 5'd12) $display("FAIL spaced_first got %0d want 12", player_hp); else passed++;
    hit_vec = 4'b0100; tick(); hit_vec = 0;
    checks++; if (player_hp !== (INV_EN ? 5'd12 : 5'd8)) $display("FAIL invuln_discard got %0d want %0d", player_hp, INV_EN ? 12 : 8); else passed++;
    for (int i = 0; i < 6; i++) tick();
    hit_vec = 4'b1000; tick(); hit_vec = 0;
    checks++; if (player_hp !== (INV_EN ? 5'd8 : 5'd4)) $display("FAIL after_window got %0d want %0d", player_hp, INV_EN ? 8 : 4); else passed++;
    for (int i = 0; i < 11; i++) tick();
  endtask

  task automatic test_lose();
    int prev, n = 0;
    while (phase == 2'b01 && n < 10) begin
      prev = int'(player_hp);
      hit_vec = 4'b0010; tick(); hit_vec = 0;
      checks++; if (int'(player_hp) != ((prev > DMG) ? prev - DMG : 0) || hit_pulse !== 1'b1) $display("FAIL lose_step got hp=%0d pulse=%0d want %0d/1", player_hp, hit_pulse, (prev > DMG) ? prev - DMG : 0); else passed++;
      n++;
      for (int i = 0; i < 11; i++) if (phase == 2'b01) tick();
    end
    checks++; if (phase !== 2'b10 || player_hp !== 5'd0 || gen_enable !== 1'b0 || invuln !== 1'b0) $display("FAIL lose_state got phase=%0d hp=%0d gen=%0d inv=%0d want 2/0/0/0", phase, player_hp, gen_enable, invuln); else passed++;
    hit_vec = 4'b1111; tick(); hit_vec = 0; tick();
    checks++; if (phase !== 2'b10 || player_hp !== 5'd0) $display("FAIL lose_terminal got phase=%0d hp=%0d want 2/0", phase, player_hp); else passed++;
    start = 1; tick(); start = 0; tick();
    checks++; if (phase !== 2'b00 || player_hp !== 5'd0) $display("FAIL lose_restart got phase=%0d hp=%0d want 0/0", phase, player_hp); else passed++;
  endtask

  task automatic test_boss_priority();
    start = 1; tick(); start = 0; tick();
    hit_vec = 4'b1001; boss = 1; tick();
    checks++; if (phase !== 2'b11 || player_hp !== 5'(HP) || hit_pulse !== 1'b0) $display("FAIL boss_priority got phase=%0d hp=%0d pulse=%0d want 3/%0d/0", phase, player_hp, hit_pulse, HP); else passed++;
    hit_vec = 0; boss = 0; tick();
    start = 1; tick(); start = 0;
    checks++; if (phase !== 2'b00 || player_hp !== 5'(HP)) $display("FAIL win_restart got phase=%0d hp=%0d want 0/%0d", phase, player_hp, HP); else passed++;
    tick();
  endtask

  task automatic test_enable_freeze();
    int bad = 0;
    start = 1; tick(); start = 0; tick();
    enable = 0;
    for (int i = 0; i < 12; i++) begin
      hit_vec = (i % 2 == 0) ? 4'b0110 : 4'b0000;
      boss = i[1];
      tick();
      if (phase !== 2'b01 || player_hp !== 5'(HP) || hit_pulse !== 1'b0 || gen_enable !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL enable_freeze got %0d bad cycles want 0", bad); else passed++;
    hit_vec = 0; boss = 0; enable = 1; tick();
    checks++; if (phase !== 2'b01 || gen_enable !== 1'b1) $display("FAIL enable_resume got phase=%0d gen=%0d want 1/1", phase, gen_enable); else passed++;
  endtask

  task automatic test_async_reset();
    hit_vec = 4'b0100; tick(); hit_vec = 0; tick(); tick();
    checks++; if (player_hp !== 5'd16 || invuln !== INV_EN) $display("FAIL pre_reset got hp=%0d inv=%0d want 16/%0d", player_hp, invuln, INV_EN); else passed++;
    #2 resetn = 0;
    #1;
    checks++; if ({phase, player_hp, hit_pulse, invuln, gen_enable} !== 10'b0) $display("FAIL async_reset got %b want 0", {phase, player_hp, hit_pulse, invuln, gen_enable}); else passed++;
    model_reset();
    @(posedge clk); #1;
    resetn = 1;
    tick();
    start = 1; tick(); start = 0;
    checks++; if (phase !== 2'b01 || player_hp !== 5'(HP) || invuln !== 1'b0) $display("FAIL fresh_fight got phase=%0d hp=%0d inv=%0d want 1/%0d/0", phase, player_hp, invuln, HP); else passed++;
    tick();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 1500; i++) begin
      enable = ($urandom % 10) != 0;
      start = ($urandom % 25) == 0;
      boss = ($urandom % 60) == 0;
      if ($urandom % 3 == 0) hit_vec = ($urandom % 2 == 0) ? 4'($urandom) : 4'b0;
      tick();
      checks++;
      if ({phase, player_hp, hit_pulse, invuln, gen_enable} !== {m_phase[1:0], m_hp[4:0], m_pulse, m_inv, m_phase == 1 && enable}) begin
        if (bad < 10) $display("FAIL random cyc=%0d got ph=%0d hp=%0d p=%0d i=%0d g=%0d want ph=%0d hp=%0d p=%0d i=%0d g=%0d", i, phase, player_hp, hit_pulse, invuln, gen_enable, m_phase, m_hp, m_pulse, m_inv, m_phase == 1 && enable);
        bad++;
      end else passed++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start();
    test_held_hit();
    test_spaced();
    test_lose();
    test_boss_priority();
    test_enable_freeze();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/battle_state_ctrl.md
BATTLE_STATE_CTRL -- requirements
Module: battle_state_ctrl

Interface
REQ-001 Parameter HP_INIT, default 20: player HP loaded on fight start; range 1..31.
REQ-002 Parameter HIT_DAMAGE, default 4: HP removed per accepted hit; range 1..31.
REQ-003 Parameter INVULN_CYCLES, default 50_000_000: post-hit invulnerability length in clocks; range 1..2^26-1.
REQ-004 CLOCK_50  in  1  sole clock; all state on rising edge.
REQ-005 resetn  in  1  reset, asynchronous, active-low.
REQ-006 enable  in  1  game-run switch; low freezes fight state.
REQ-007 start  in  1  start/restart button, level; rising edge acts.
REQ-008 hit_vec  in  4  collision_detected from the four bone collision detectors, any bit = contact.
REQ-009 boss_defeated  in  1  level from boss health block.
REQ-010 phase  out  2  00 IDLE, 01 FIGHT, 10 LOSE, 11 WIN; registered.
REQ-011 player_hp  out  5  remaining HP; registered.
REQ-012 hit_pulse  out  1  one-cycle pulse per accepted hit; registered.
REQ-013 invuln  out  1  high during invulnerability window; registered.
REQ-014 gen_enable  out  1  enable for bullet generators = (phase==FIGHT) & enable; combinational from registered phase.

Function
REQ-015 Module SHALL register start and hit_any=|hit_vec every cycle into start_q, hit_q; start_rise=start&~start_q, hit_rise=hit_any&~hit_q, evaluated in all states.
REQ-016 IDLE: start_rise & enable SHALL move to FIGHT and load player_hp=HP_INIT, invuln=0 on the same edge.
REQ-017 FIGHT with enable=0: phase, player_hp, invuln counter SHALL hold; hit_rise and boss_defeated ignored; hit_q still tracks.
REQ-018 FIGHT, enable=1, boss_defeated=1: SHALL move to WIN next edge; takes priority over a simultaneous hit_rise (no damage, no hit_pulse).
REQ-019 FIGHT, enable=1, hit_rise=1, invuln=0, no boss_defeated: accepted hit; on that edge player_hp=max(hp-HIT_DAMAGE,0), hit_pulse=1 for exactly one cycle.
REQ-020 Accepted hit leaving player_hp=0 SHALL move to LOSE on the same edge; invuln not started.
REQ-021 hit_rise while invuln=1 SHALL be discarded, not deferred; a collision held continuously SHALL count once.
REQ-022 LOSE and WIN: terminal; player_hp frozen; start_rise SHALL move to IDLE (player_hp kept until next fight start).
REQ-023 Simultaneous multiple hit_vec bits SHALL count as one hit.
REQ-024 Subtraction SHALL be 6-bit internally, saturating at 0; no wrap.
REQ-025 Encoding 2'b00..2'b11 only; no unreachable states.

Reset
REQ-026 resetn low SHALL asynchronously force phase=IDLE, player_hp=0, hit_pulse=0, invuln=0, invuln counter=0, start_q=0, hit_q=0; gen_enable=0 follows.
REQ-027 Reset asserted mid-fight or mid-invulnerability SHALL abort immediately; first post-reset start_rise begins a fresh fight.

Configuration
REQ-028 Macro BATTLE_INVULN_EN defined: 26-bit down-counter loaded INVULN_CYCLES on each accepted non-fatal hit; invuln=1 for exactly INVULN_CYCLES cycles starting the edge after hit_pulse; counter decrements only when FIGHT & enable.
REQ-029 Macro BATTLE_INVULN_EN undefined: no counter synthesised, invuln tied 0, every hit_rise in FIGHT (enable=1) is accepted.

Verification (HP_INIT=20, HIT_DAMAGE=4, INVULN_CYCLES=8)
REQ-030 Reset, enable=1, start pulse -> phase 00->01 one edge after start rise, player_hp=20, gen_enable=1.
REQ-031 hit_vec=4'b0010 held 20 cycles -> single hit_pulse, player_hp=16; with _EN invuln high exactly 8 cycles.
REQ-032 With _EN, second hit_rise 3 cycles after first -> ignored, hp stays 16; hit_rise 10 cycles after -> hp=12.
REQ-033 Five spaced hits (gap >=10) -> hp 16,12,8,4,0; fifth edge phase=10, gen_enable=0; start pulse -> phase=00.
REQ-034 hit_vec=4'b1001 rising with boss_defeated=1 same cycle -> phase=11, hp unchanged, no hit_pulse.
REQ-035 enable=0 during FIGHT with hit pulses and boss_defeated -> nothing changes; resetn low mid-invuln -> all outputs to reset values without a clock edge.
